// File: rtl/uart_tx_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart_tx_frame transmitter:
//   tx_state_e  - transmit FSM state encoding
//   PAR_*       - cfg_parity encodings (2'b11 is reserved and behaves as none)
//   frame_bits  - serial bit count of one frame for a given configuration
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input logic [1:0]  parity,
                                               input logic        stop2);
        int unsigned n;
        n = 1 + data_bits;
        if (parity == PAR_EVEN || parity == PAR_ODD) n = n + 1;
        n = n + (stop2 ? 2 : 1);
        return n;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO feeding the transmitter when UART_TX_FIFO_EN is defined.
// No bypass: a word pushed into an empty FIFO is visible on the next cycle.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   push, push_data    - write request (ignored when full)
//   pop                - read request (ignored when empty)
//   pop_data           - head entry (valid while !empty)
//   full, empty        - occupancy flags
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Double-buffered UART transmitter with runtime parity / stop-bit selection.
// Optional build macro: UART_TX_FIFO_EN replaces the single holding register
// with a FIFO_DEPTH-entry uart_tx_fifo; serial timing is the same either way.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   clk_div               - clk cycles per bit (0 treated as 1), latched per frame
//   cfg_parity, cfg_stop2 - frame format, latched per frame
//   in_valid/in_ready/in_data - byte input handshake
//   tx                    - registered serial output, idle high
//   busy                  - frame in progress
//   tx_done               - one-cycle pulse on the final stop-bit cycle
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_W-1:0]     clk_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int unsigned BC_W = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     div_q, div_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 en_q;

    logic                 push, pop, have_data, start_frame, bit_end;
    logic [DATA_BITS-1:0] head_data;

    assign push = in_valid && in_ready;

`ifdef UART_TX_FIFO_EN
    logic fifo_full, fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready  = en_q && !fifo_full;
    assign have_data = !fifo_empty;
`else
    logic                 hold_valid_q, hold_valid_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;

    // push and pop never coincide: push needs !hold_valid, pop needs hold_valid.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (pop)  hold_valid_d = 1'b0;
        if (push) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign in_ready  = en_q && !hold_valid_q;
    assign have_data = hold_valid_q;
    assign head_data = hold_data_q;
`endif

    assign bit_end = (cnt_q == div_q - 1'b1);

    // tx/busy/tx_done are registered from the current state, so all three lag
    // the state register by one cycle and stay mutually aligned.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        tx_d        = 1'b1;
        busy_d      = (state_q != IDLE);
        done_d      = 1'b0;
        start_frame = 1'b0;
        pop         = 1'b0;

        if (state_q != IDLE && !bit_end) cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (have_data) start_frame = 1'b1;
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                tx_d = par_bit_q;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && bit_cnt_q == '0) begin
                        bit_cnt_d = BC_W'(1);
                    end else begin
                        done_d = 1'b1;
                        if (have_data) start_frame = 1'b1;
                        else           state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            pop       = 1'b1;
            state_d   = START;
            cnt_d     = '0;
            bit_cnt_d = '0;
            shift_d   = head_data;
            div_d     = (clk_div == '0) ? CNT_W'(1) : clk_div;
            par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_bit_d = (^head_data) ^ (cfg_parity == PAR_ODD);
            stop2_d   = cfg_stop2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            en_q      <= 1'b1;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed self-checking bench for uart_tx_frame (DATA_BITS=8, FIFO_DEPTH=4).
// The FIFO section is compiled only when UART_TX_FIFO_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] clk_div;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        tx;
    logic        busy;
    logic        tx_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int t_first;

    uart_tx_frame #(
        .DATA_BITS  (8),
        .CNT_W      (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_div    (clk_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers one byte; returns on the negedge after the accepting posedge.
    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Samples tx once per cycle for a whole frame. pre: one idle-high sample
    // precedes the start bit; post: line returns to idle afterwards.
    task automatic check_frame(input string tag, input logic [7:0] d,
                               input bit has_par, input logic pbit,
                               input bit stop2, input int div, input int total,
                               input bit pre, input bit post);
        logic exp_q[$];
        int   bad, busy_n, done_n, done_at, idx;
        bad = -1; busy_n = 0; done_n = 0; done_at = -1; idx = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (has_par) exp_q.push_back(pbit);
        exp_q.push_back(1'b1);
        if (stop2) exp_q.push_back(1'b1);
        if (pre) begin
            @(negedge clk);
            chk({tag, "_pre_tx"}, {31'd0, tx}, 32'd1);
        end
        foreach (exp_q[b]) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                if (tx !== exp_q[b] && bad < 0) bad = idx;
                if (busy === 1'b1) busy_n++;
                if (tx_done === 1'b1) begin
                    done_n++;
                    done_at = idx;
                    last_done_cyc = cyc;
                end
                idx++;
            end
        end
        chk({tag, "_wave_first_bad"}, bad, 32'hFFFF_FFFF);
        chk({tag, "_busy_cycles"}, busy_n, total);
        chk({tag, "_done_pulses"}, done_n, 32'd1);
        chk({tag, "_done_pos"}, done_at, total - 1);
        if (post) begin
            @(negedge clk);
            chk({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
            chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        clk_div    = 32'd4;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;

        // Reset state
        #12;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // 8N1, div 4, 0xA5: 10 bits x 4 = 40 cycles
        send(8'hA5);
        check_frame("8n1_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 4, 40, 1'b1, 1'b1);

        // Even parity, 0x07 has three ones -> parity bit 1; 11 bits = 44
        cfg_parity = 2'b01;
        send(8'h07);
        check_frame("even_07", 8'h07, 1'b1, 1'b1, 1'b0, 4, 44, 1'b1, 1'b1);

        // Odd parity, 0x07 -> parity bit 0
        cfg_parity = 2'b10;
        send(8'h07);
        check_frame("odd_07", 8'h07, 1'b1, 1'b0, 1'b0, 4, 44, 1'b1, 1'b1);

        // Two stop bits: stop high 8 cycles, 44 total
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b1;
        send(8'hA5);
        check_frame("stop2_a5", 8'hA5, 1'b0, 1'b0, 1'b1, 4, 44, 1'b1, 1'b1);
        cfg_stop2 = 1'b0;

        // Back-to-back 0x55 then 0xAA: no gap, done pulses 40 cycles apart
        send(8'h55);
        fork
            send(8'hAA);
            begin
                check_frame("b2b_55", 8'h55, 1'b0, 1'b0, 1'b0, 4, 40, 1'b1, 1'b0);
                t_first = last_done_cyc;
                check_frame("b2b_aa", 8'hAA, 1'b0, 1'b0, 1'b0, 4, 40, 1'b0, 1'b1);
                chk("b2b_done_gap", last_done_cyc - t_first, 32'd40);
            end
        join

        // clk_div 0 and 1: one cycle per bit, 10-cycle frames
        clk_div = 32'd0;
        send(8'h5A);
        check_frame("div0_5a", 8'h5A, 1'b0, 1'b0, 1'b0, 1, 10, 1'b1, 1'b1);
        clk_div = 32'd1;
        send(8'h96);
        check_frame("div1_96", 8'h96, 1'b0, 1'b0, 1'b0, 1, 10, 1'b1, 1'b1);

        // Reserved parity code 2'b11 behaves as no parity
        cfg_parity = 2'b11;
        send(8'h81);
        check_frame("par11_81", 8'h81, 1'b0, 1'b0, 1'b0, 1, 10, 1'b1, 1'b1);
        cfg_parity = 2'b00;

        // clk_div change mid-frame only affects the following frame
        clk_div = 32'd4;
        send(8'hC3);
        fork
            check_frame("divchg_c3", 8'hC3, 1'b0, 1'b0, 1'b0, 4, 40, 1'b1, 1'b1);
            begin
                repeat (12) @(negedge clk);
                clk_div = 32'd2;
            end
        join
        send(8'h3C);
        check_frame("div2_3c", 8'h3C, 1'b0, 1'b0, 1'b0, 2, 20, 1'b1, 1'b1);

        // Reset during the 3rd data bit of 0x00 (tx low there)
        clk_div = 32'd4;
        send(8'h00);
        repeat (15) @(negedge clk);
        chk("pre_abort_tx", {31'd0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_post_ready", {31'd0, in_ready}, 32'd1);
        send(8'h3C);
        check_frame("after_rst_3c", 8'h3C, 1'b0, 1'b0, 1'b0, 4, 40, 1'b1, 1'b1);

`ifdef UART_TX_FIFO_EN
        // FIFO: one byte in flight plus four queued -> full, then in-order drain
        send(8'h11);
        fork
            begin
                send(8'h22);
                send(8'h33);
                send(8'h44);
                send(8'h55);
                chk("fifo_full_ready", {31'd0, in_ready}, 32'd0);
            end
            begin
                check_frame("fifo_11", 8'h11, 1'b0, 1'b0, 1'b0, 4, 40, 1'b1, 1'b0);
                check_frame("fifo_22", 8'h22, 1'b0, 1'b0, 1'b0, 4, 40, 1'b0, 1'b0);
                check_frame("fifo_33", 8'h33, 1'b0, 1'b0, 1'b0, 4, 40, 1'b0, 1'b0);
                check_frame("fifo_44", 8'h44, 1'b0, 1'b0, 1'b0, 4, 40, 1'b0, 1'b0);
                check_frame("fifo_55", 8'h55, 1'b0, 1'b0, 1'b0, 4, 40, 1'b0, 1'b1);
            end
        join
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised, double-buffered UART transmitter; next generation of the team's fixed 8N1 transmitter. Runtime-configurable parity and stop bits. Valid/ready byte input replaces edge-triggered start. Sits between the user-side register/FIFO logic and the serial pad; clk_div supplied by the UART CSR block.

Parameters:
DATA_BITS, 8, payload width per frame (5..9 legal), LSB transmitted first.
CNT_W, 32, width of clk_div and the internal baud counter.
FIFO_DEPTH, 4, entries of the optional input FIFO (power of two, >=2; used only with UART_TX_FIFO_EN).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
clk_div  in  CNT_W  clk cycles per bit; 0 treated as 1
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none (reserved)
cfg_stop2  in  1  1 = two stop bits, 0 = one
in_valid  in  1  byte offered
in_ready  out  1  byte accepted when in_valid && in_ready
in_data  in  DATA_BITS  payload
tx  out  1  serial line, idle high
busy  out  1  frame in progress (state != IDLE)
tx_done  out  1  one-cycle pulse at end of final stop bit

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, tx_done=0, in_ready=0 while reset is asserted; in_ready=1 from the first clk edge after release. State IDLE, counters 0, holding register empty. Reset mid-frame aborts the frame; tx returns high immediately.
- Buffering (no FIFO): one holding register. in_ready = !hold_valid. The holding register transfers to the shift register at frame start, so the next byte is accepted during the current frame.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START.
  - IDLE: tx=1. If hold_valid, load shift reg, latch cfg_parity/cfg_stop2/clk_div (frame-stable copies), clear hold_valid, go START.
  - START: tx=0 for clk_div cycles.
  - DATA: tx=shift[0], DATA_BITS bits of clk_div cycles each; shift right per bit.
  - PARITY: entered only if latched parity is 01/10. tx = XOR of payload (even) or its inverse (odd).
  - STOP: tx=1 for clk_div cycles, doubled if latched cfg_stop2. Last cycle: tx_done=1. If hold_valid, go directly to START (no idle gap, load as in IDLE); else IDLE.
- Timing: byte accepted at edge N in IDLE -> state START and tx=0 from edge N+2 (N+1 loads hold; N+2 registers tx). tx is a registered output, glitch-free.
- Baud counter counts 0..div-1 per bit; div = max(clk_div,1). A clk_div change mid-frame has no effect until the next frame start.
- busy=1 from START entry to the STOP->IDLE transition; stays 1 across back-to-back frames.
- Frame length in bits: 1 + DATA_BITS + (parity?1:0) + (stop2?2:1).
- Simultaneous accept and frame-start transfer in the same cycle is legal; there is no data loss or duplication.

Optional Feature:
UART_TX_FIFO_EN: replaces the holding register with a FIFO_DEPTH-entry FIFO. in_ready = !full; the FSM pops on frame start; simultaneous push and pop when full is refused (ready=0); push and pop when empty is not bypassed (one-cycle latency is kept). Without the macro: single holding register as described above. Serial timing is identical in both builds.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP); parity encodings PAR_NONE/PAR_EVEN/PAR_ODD; frame-length helper function.
- Sub-module uart_tx_fifo (synchronous FIFO, parametrised width/depth): instantiated only under UART_TX_FIFO_EN.

Test Plan:
- clk_div=4, 8N1, in_data=0xA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; 40 cycles total; single tx_done pulse; busy high 40 cycles.
- cfg_parity=01, data 0x07 -> parity bit 1; cfg_parity=10, data 0x07 -> parity bit 0; cfg_stop2=1 -> stop high 8 cycles at clk_div=4.
- Two bytes 0x55, 0xAA offered back-to-back -> second accepted during the first frame, start bit immediately after the first stop bit, busy never drops, two tx_done pulses 40 cycles apart.
- clk_div=0 and clk_div=1 -> each bit 1 cycle; 8N1 frame = 10 cycles.
- rst_n asserted in the 3rd data bit -> tx=1, busy=0 asynchronously; after release, a new byte 0x3C transmits a correct full frame.
- UART_TX_FIFO_EN, FIFO_DEPTH=4: push 5 bytes while busy -> in_ready deasserts when full; all bytes emitted in order; clk_div changed mid-frame affects only the next frame.
